event_fifo: RTL

//  Shared event FIFO between the event builder / comms controller and the external interface.
//  - Stores 63-bit packets written by the comms controller (output_event, write_fifo_n).
//  - Presents the head packet to the external interface as tx_data (first-word fall-through).
//  - Reports full/half/empty/count for UART diagnostics and backpressure.
//  - Keeps sticky overflow/underflow flags and a high-water mark.

---
 rtl/event_fifo_if.sv | 30 +++
 rtl/event_fifo.sv | 92 +++++++++
 2 files changed

// File: rtl/event_fifo_if.sv
// Handshake bundle between the comms controller (master) and the shared event FIFO (slave).
interface event_fifo_if #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned FIFO_BITS = 11
);
  logic [WIDTH-2:0]   data_in;
  logic               write_n;
  logic               read_n;
  logic               clear_flags;
  logic [WIDTH-2:0]   data_out;
  logic               fifo_empty;
  logic               fifo_half;
  logic               fifo_full;
  logic [FIFO_BITS:0] fifo_counter;
  logic [FIFO_BITS:0] fifo_high_water;
  logic               overflow;
  logic               underflow;

  modport master (
    output data_in, write_n, read_n, clear_flags,
    input  data_out, fifo_empty, fifo_half, fifo_full,
    input  fifo_counter, fifo_high_water, overflow, underflow
  );

  modport slave (
    input  data_in, write_n, read_n, clear_flags,
    output data_out, fifo_empty, fifo_half, fifo_full,
    output fifo_counter, fifo_high_water, overflow, underflow
  );
endinterface

// File: rtl/event_fifo.sv
// Shared first-word-fall-through event FIFO with registered occupancy flags,
// sticky overflow/underflow and a high-water mark.
module event_fifo #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned FIFO_BITS = 11
) (
  input logic         clk,
  input logic         reset,
  event_fifo_if.slave bus
);
  localparam int unsigned DW    = WIDTH - 1;
  localparam int unsigned CW    = FIFO_BITS + 1;
  localparam int unsigned DEPTH = 1 << FIFO_BITS;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(DEPTH / 2);

  logic [DW-1:0]        mem [DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]        count, count_nxt, high_water, high_water_nxt;
  logic [DW-1:0]        data_q, data_nxt;
  logic                 empty_q, half_q, full_q, ovf_q, udf_q;
  logic                 ovf_nxt, udf_nxt;
  logic                 wr_acc, rd_acc;

  // Next-state: accepted strobes, occupancy, flags and the next head word.
  always_comb begin
    wr_acc         = !bus.write_n && !full_q;
    rd_acc         = !bus.read_n && !empty_q;
    wr_ptr_nxt     = wr_ptr + FIFO_BITS'(wr_acc);
    rd_ptr_nxt     = rd_ptr + FIFO_BITS'(rd_acc);
    count_nxt      = count + CW'(wr_acc) - CW'(rd_acc);
    high_water_nxt = high_water;
    data_nxt       = '0;

    if (bus.clear_flags)
      high_water_nxt = count;
    else if (count_nxt > high_water)
      high_water_nxt = count_nxt;

    ovf_nxt = (!bus.write_n && full_q) || (ovf_q && !bus.clear_flags);
    udf_nxt = (!bus.read_n && empty_q) || (udf_q && !bus.clear_flags);

    // A write that lands in an otherwise empty FIFO bypasses storage.
    if (count_nxt != '0) begin
      if (wr_acc && count_nxt == CW'(1))
        data_nxt = bus.data_in;
      else
        data_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      high_water <= '0;
      data_q     <= '0;
      empty_q    <= 1'b1;
      half_q     <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      high_water <= high_water_nxt;
      data_q     <= data_nxt;
      empty_q    <= (count_nxt == '0);
      half_q     <= (count_nxt >= HALF_CNT);
      full_q     <= (count_nxt == FULL_CNT);
      ovf_q      <= ovf_nxt;
      udf_q      <= udf_nxt;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset)
      mem[wr_ptr] <= bus.data_in;
  end

  assign bus.data_out        = data_q;
  assign bus.fifo_empty      = empty_q;
  assign bus.fifo_half       = half_q;
  assign bus.fifo_full       = full_q;
  assign bus.fifo_counter    = count;
  assign bus.fifo_high_water = high_water;
  assign bus.overflow        = ovf_q;
  assign bus.underflow       = udf_q;
endmodule
